core_boot_loader: RTL
=====================

Name: core_boot_loader

Overview:
- Byte-stream programming front end that sits directly upstream of the single-cycle core's setup interface.
- Receives framed command packets from a host link (UART receiver or testbench) over a valid/ready byte handshake.
- Assembles 32-bit little-endian words from the payload bytes, then issues one-cycle write strobes into instruction memory and the register file, and loads the PC start address.
- Holds the core in setup mode until a RUN command arrives.

Parameters:
- RESET_PC, 32'h00000000, reset value of pc_start_addr.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between payload bytes before the packet is aborted; 0 disables the timeout.
- TO_W, 16, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  host byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready
- setup  out  1  1 holds the core in load/setup mode; 0 means the core runs
- inst_mem_we  out  1  one-cycle instruction memory write strobe
- inst_mem_addr  out  32  instruction memory write address
- inst_mem_data  out  32  instruction memory write data
- reg_load_we  out  1  one-cycle register file load strobe
- load_reg_addr  out  5  register index for the load
- load_reg_data  out  32  register load data
- pc_first_we  out  1  one-cycle strobe that loads pc_start_addr into the PC
- pc_start_addr  out  32  PC start address, held between updates
- busy  out  1  1 while a packet is partially received or committing
- err_code  out  2  sticky error: 0 none, 1 bad command, 2 timeout

Behaviour:
- Reset: everything is synchronous to clk; rst is synchronous and active-high.
  - State returns to IDLE.
  - setup=1, in_ready=1.
  - All strobes =0, busy=0, err_code=0.
  - inst_mem_addr, inst_mem_data, load_reg_data and load_reg_addr =0.
  - pc_start_addr=RESET_PC.
  - Reset asserted mid-packet discards the partial packet.
- Command bytes, accepted in IDLE:
  - 0x01 LOAD_INST: 4 address bytes, then 4 data bytes.
  - 0x02 LOAD_REG: 1 register byte (bits [4:0] used, [7:5] ignored), then 4 data bytes.
  - 0x03 SET_PC: 4 address bytes.
  - 0x04 RUN: no payload.
- Words are little-endian: the first byte lands in [7:0], the fourth in [31:24]. A 2-bit byte counter indexes the word.
- States: IDLE, GET_ADDR, GET_REG, GET_DATA, COMMIT, RUN.
- IDLE transitions:
  - 0x01 or 0x03 → GET_ADDR.
  - 0x02 → GET_REG.
  - 0x04 → RUN, with setup←0 on the next cycle.
  - Any other byte: err_code←1, the byte is consumed, state stays IDLE.
  - Any legal command byte clears err_code to 0.
- Payload transitions:
  - GET_ADDR after byte 4: LOAD_INST → GET_DATA; SET_PC → COMMIT.
  - GET_REG after 1 byte → GET_DATA.
  - GET_DATA after byte 4 → COMMIT.
- COMMIT lasts exactly one cycle:
  - in_ready=0.
  - Exactly one strobe is high for that cycle, per the command: inst_mem_we, reg_load_we, or pc_first_we with pc_start_addr updated the same cycle.
  - Address and data outputs are registered and stable during the strobe, and hold their value afterwards.
  - Next state is IDLE.
- Latency: last payload byte accepted at cycle N → strobe high at cycle N+1 → next byte accepted no earlier than cycle N+2.
- in_ready=1 in every state except COMMIT. A byte presented during COMMIT is not consumed and must be held by the host.
- busy=1 in GET_ADDR, GET_REG, GET_DATA and COMMIT.
- LOAD_REG to x0 is still strobed; the register file ignores it.
- RUN state:
  - setup=0, no strobes.
  - Byte 0x05 HALT → setup←1, state IDLE.
  - Any other byte is consumed with err_code←1, state stays RUN.
- Timeout:
  - The counter clears on every accepted byte and on state entry.
  - It increments each cycle spent in GET_* without a transfer.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, err_code←2, no strobe issued.
  - The timeout never fires in IDLE, COMMIT or RUN.
- Simultaneous rst and in_valid: reset wins and the byte is not consumed.
- The loader performs no address alignment check; inst_mem_addr passes through unmodified.

Test Plan:
- Reset, then send 01 00 01 00 00 13 00 00 00 → one cycle with inst_mem_we=1, inst_mem_addr=0x00000100, inst_mem_data=0x00000013. in_ready=0 that cycle. busy=0 two cycles after the last byte.
- Send 02 25 EF BE AD DE → reg_load_we pulse with load_reg_addr=5 (bits [7:5] dropped) and load_reg_data=0xDEADBEEF; no other strobe fires.
- Send 03 00 02 00 00, then 04 → pc_first_we pulse with pc_start_addr=0x00000200. setup falls to 0 the cycle after 0x04 is accepted. Then send 05 → setup=1, state IDLE.
- Send 7F → err_code=1, no strobe. Then send 03 …, and err_code returns to 0 on acceptance of 0x03.
- With TIMEOUT_CYCLES=8: send 01 AA, then hold in_valid low for 8 cycles → err_code=2, busy=0, no inst_mem_we. The following 01 + 8 payload bytes load normally.
- Assert rst after 5 payload bytes of a LOAD_INST → no strobe, setup=1, pc_start_addr=RESET_PC. A fresh packet after reset completes correctly.

Source files
------------

// File: rtl/core_boot_loader.sv
// core_boot_loader: framed byte-stream loader for the single-cycle core.
// Ports: clk/rst; in_data/in_valid/in_ready byte handshake in;
// inst_mem_*, reg_load_we/load_reg_*, pc_first_we/pc_start_addr load
// strobes and data out; setup (core hold), busy, sticky err_code.
module core_boot_loader #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        setup,
  output logic        inst_mem_we,
  output logic [31:0] inst_mem_addr,
  output logic [31:0] inst_mem_data,
  output logic        reg_load_we,
  output logic [4:0]  load_reg_addr,
  output logic [31:0] load_reg_data,
  output logic        pc_first_we,
  output logic [31:0] pc_start_addr,
  output logic        busy,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_REG,
    S_GET_DATA,
    S_COMMIT,
    S_RUN
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic [1:0]      r_cmd;
  logic [1:0]      r_cnt;
  logic [23:0]     r_buf;
  logic [31:0]     r_addr;
  logic [4:0]      r_reg;
  logic [TO_W-1:0] r_to;
  logic            r_setup;
  logic            r_iwe;
  logic            r_rwe;
  logic            r_pwe;
  logic [31:0]     r_iaddr;
  logic [31:0]     r_idata;
  logic [4:0]      r_raddr;
  logic [31:0]     r_rdata;
  logic [31:0]     r_pc;
  logic [1:0]      r_err;

  logic            w_xfer;
  logic            w_get;
  logic            w_to_hit;
  logic [31:0]     w_word;

  assign in_ready = (r_state != S_COMMIT);
  assign w_xfer   = in_valid && in_ready;
  assign w_get    = (r_state == S_GET_ADDR) ||
                    (r_state == S_GET_REG)  ||
                    (r_state == S_GET_DATA);
  assign w_to_hit = TO_EN && (r_to == TO_LAST);
  // The fourth byte goes straight into the top lane of the word.
  assign w_word   = {in_data, r_buf};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_reg   <= '0;
      r_to    <= '0;
      r_setup <= 1'b1;
      r_iwe   <= 1'b0;
      r_rwe   <= 1'b0;
      r_pwe   <= 1'b0;
      r_iaddr <= '0;
      r_idata <= '0;
      r_raddr <= '0;
      r_rdata <= '0;
      r_pc    <= RESET_PC;
      r_err   <= '0;
    end else begin
      r_iwe <= 1'b0;
      r_rwe <= 1'b0;
      r_pwe <= 1'b0;

      if (w_get && !w_xfer && TO_EN && !w_to_hit)
        r_to <= r_to + 1'b1;
      else
        r_to <= '0;

      if (w_xfer && (r_state == S_GET_ADDR || r_state == S_GET_DATA)) begin
        r_cnt <= r_cnt + 2'd1;
        case (r_cnt)
          2'd0:    r_buf[7:0]   <= in_data;
          2'd1:    r_buf[15:8]  <= in_data;
          2'd2:    r_buf[23:16] <= in_data;
          default: ;
        endcase
      end

      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_xfer) begin
            case (in_data)
              8'h01, 8'h03: begin
                r_cmd   <= in_data[1:0];
                r_err   <= 2'd0;
                r_state <= S_GET_ADDR;
              end
              8'h02: begin
                r_cmd   <= 2'd2;
                r_err   <= 2'd0;
                r_state <= S_GET_REG;
              end
              8'h04: begin
                r_err   <= 2'd0;
                r_setup <= 1'b0;
                r_state <= S_RUN;
              end
              default: r_err <= 2'd1;
            endcase
          end
        end
        S_GET_ADDR: begin
          if (w_xfer && r_cnt == 2'd3) begin
            if (r_cmd == 2'd3) begin
              r_pc    <= w_word;
              r_pwe   <= 1'b1;
              r_state <= S_COMMIT;
            end else begin
              r_addr  <= w_word;
              r_state <= S_GET_DATA;
            end
          end
        end
        S_GET_REG: begin
          if (w_xfer) begin
            r_reg   <= in_data[4:0];
            r_cnt   <= '0;
            r_state <= S_GET_DATA;
          end
        end
        S_GET_DATA: begin
          if (w_xfer && r_cnt == 2'd3) begin
            r_state <= S_COMMIT;
            if (r_cmd == 2'd2) begin
              r_raddr <= r_reg;
              r_rdata <= w_word;
              r_rwe   <= 1'b1;
            end else begin
              r_iaddr <= r_addr;
              r_idata <= w_word;
              r_iwe   <= 1'b1;
            end
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        S_RUN: begin
          if (w_xfer) begin
            if (in_data == 8'h05) begin
              r_setup <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_err <= 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Inter-byte gap too long: drop the partial packet.
      if (w_get && !w_xfer && w_to_hit) begin
        r_state <= S_IDLE;
        r_err   <= 2'd2;
      end
    end
  end

  assign setup         = r_setup;
  assign inst_mem_we   = r_iwe;
  assign inst_mem_addr = r_iaddr;
  assign inst_mem_data = r_idata;
  assign reg_load_we   = r_rwe;
  assign load_reg_addr = r_raddr;
  assign load_reg_data = r_rdata;
  assign pc_first_we   = r_pwe;
  assign pc_start_addr = r_pc;
  assign busy          = w_get || (r_state == S_COMMIT);
  assign err_code      = r_err;

endmodule
